// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar message path; SONAR_MSG_CHECKSUM_EN appends an XOR checksum char.
// Purely declarative: no latency, no flow control.
package sonar_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CARREGA = 4'd1,
        ST_ENVIA   = 4'd2,
        ST_ESPERA  = 4'd3,
        ST_PROXIMO = 4'd4,
        ST_FIM     = 4'd5
    } state_t;

    typedef struct packed {
        logic [6:0] c;
        logic [6:0] d;
        logic [6:0] u;
    } ang_t;

    localparam int         IDX_W            = 4;
    localparam logic [6:0] CHAR_INVALID     = 7'h3F;
    localparam logic [2:0] BCD_ASCII_PREFIX = 3'b011;

`ifdef SONAR_MSG_CHECKSUM_EN
    localparam logic [IDX_W-1:0] LAST_IDX = 4'd8;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = 4'd7;
`endif

    function automatic logic [6:0] bcd_to_ascii(input logic [3:0] digit);
        return (digit > 4'd9) ? CHAR_INVALID : {BCD_ASCII_PREFIX, digit};
    endfunction

endpackage

// File: rtl/sonar_char_sel.sv
// Maps a char index to the ASCII char of the message (BCD digits converted, invalid ones shown as '?').
// Combinational, no backpressure; index 8 yields the XOR checksum when SONAR_MSG_CHECKSUM_EN is set.
module sonar_char_sel
    import sonar_pkg::*;
#(
    parameter logic [6:0] SEP_CHAR = 7'h2C,
    parameter logic [6:0] END_CHAR = 7'h23
) (
    input  logic [IDX_W-1:0] idx,
    input  ang_t             ang,
    input  logic [11:0]      medida,
    output logic [6:0]       char_dat
);

    logic [6:0] chars [0:7];

    always_comb begin
        chars[0] = ang.c;
        chars[1] = ang.d;
        chars[2] = ang.u;
        chars[3] = SEP_CHAR;
        chars[4] = bcd_to_ascii(medida[11:8]);
        chars[5] = bcd_to_ascii(medida[7:4]);
        chars[6] = bcd_to_ascii(medida[3:0]);
        chars[7] = END_CHAR;
    end

`ifdef SONAR_MSG_CHECKSUM_EN
    logic [6:0] checksum;

    always_comb begin
        checksum = '0;
        for (int i = 0; i < 8; i++) begin
            checksum = checksum ^ chars[i];
        end
    end

    always_comb begin
        char_dat = '0;
        if (idx <= 4'd7) begin
            char_dat = chars[idx[2:0]];
        end else if (idx == 4'd8) begin
            char_dat = checksum;
        end
    end
`else
    always_comb begin
        char_dat = '0;
        if (idx <= 4'd7) begin
            char_dat = chars[idx[2:0]];
        end
    end
`endif

endmodule

// File: rtl/sonar_msg_sequencer.sv
// Serialises a captured angle/distance pair as ASCII chars to a UART-style transmitter; 2 cycles from start or tx_pronto to tx_partida.
// Waits indefinitely in ESPERA for tx_pronto; start requests while busy are dropped. SONAR_MSG_CHECKSUM_EN adds a 9th char.
module sonar_msg_sequencer
    import sonar_pkg::*;
#(
    parameter logic [6:0] SEP_CHAR = 7'h2C,
    parameter logic [6:0] END_CHAR = 7'h23
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        iniciar,
    input  logic [23:0] angulo,
    input  logic [11:0] medida,
    output logic        tx_partida,
    output logic [6:0]  tx_dados,
    input  logic        tx_pronto,
    output logic        ocupado,
    output logic        pronto,
    output logic [3:0]  db_estado
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    ang_t             ang_q, ang_d;
    logic [11:0]      med_q, med_d;
    logic             tx_partida_q, tx_partida_d;
    logic [6:0]       tx_dados_q, tx_dados_d;
    logic             ocupado_q, ocupado_d;
    logic             pronto_q, pronto_d;
    logic [6:0]       sel_dat;

    // The MSB of each angle byte carries no information.
    logic unused_ang_pad;
    assign unused_ang_pad = angulo[23] ^ angulo[15] ^ angulo[7];

    sonar_char_sel #(
        .SEP_CHAR (SEP_CHAR),
        .END_CHAR (END_CHAR)
    ) u_char_sel (
        .idx      (idx_d),
        .ang      (ang_q),
        .medida   (med_q),
        .char_dat (sel_dat)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ang_d   = ang_q;
        med_d   = med_q;
        case (state_q)
            ST_IDLE: begin
                if (iniciar) begin
                    state_d = ST_CARREGA;
                    ang_d   = '{c: angulo[22:16], d: angulo[14:8], u: angulo[6:0]};
                    med_d   = medida;
                end
            end
            ST_CARREGA: begin
                idx_d   = '0;
                state_d = ST_ENVIA;
            end
            ST_ENVIA: begin
                state_d = ST_ESPERA;
            end
            ST_ESPERA: begin
                if (tx_pronto) begin
                    state_d = ST_PROXIMO;
                end
            end
            ST_PROXIMO: begin
                if (idx_q < LAST_IDX) begin
                    idx_d   = idx_q + 4'd1;
                    state_d = ST_ENVIA;
                end else begin
                    state_d = ST_FIM;
                end
            end
            ST_FIM: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        tx_partida_d = (state_d == ST_ENVIA);
        tx_dados_d   = (state_d == ST_ENVIA) ? sel_dat : tx_dados_q;
        ocupado_d    = (state_d != ST_IDLE);
        pronto_d     = (state_d == ST_FIM);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            ang_q        <= '0;
            med_q        <= '0;
            tx_partida_q <= 1'b0;
            tx_dados_q   <= '0;
            ocupado_q    <= 1'b0;
            pronto_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ang_q        <= ang_d;
            med_q        <= med_d;
            tx_partida_q <= tx_partida_d;
            tx_dados_q   <= tx_dados_d;
            ocupado_q    <= ocupado_d;
            pronto_q     <= pronto_d;
        end
    end

    assign tx_partida = tx_partida_q;
    assign tx_dados   = tx_dados_q;
    assign ocupado    = ocupado_q;
    assign pronto     = pronto_q;
    assign db_estado  = state_q;

endmodule

// File: tb/tb_sonar_msg_sequencer.sv
// Directed and randomized messages against a queue-based model of the expected char stream.
module tb_sonar_msg_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        iniciar = 1'b0;
    logic        tx_pronto = 1'b0;
    logic [23:0] angulo = '0;
    logic [11:0] medida = '0;
    logic        tx_partida;
    logic [6:0]  tx_dados;
    logic        ocupado;
    logic        pronto;
    logic [3:0]  db_estado;

    int n_checks = 0;
    int n_pass   = 0;
    logic [6:0] exp_q [$];

    sonar_msg_sequencer dut (
        .clock      (clock),
        .reset      (reset),
        .iniciar    (iniciar),
        .angulo     (angulo),
        .medida     (medida),
        .tx_partida (tx_partida),
        .tx_dados   (tx_dados),
        .tx_pronto  (tx_pronto),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .db_estado  (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    function automatic logic [6:0] digit_char(input logic [3:0] d);
        if (d <= 4'd9) return 7'h30 + 7'(d);
        return 7'h3F;
    endfunction

    task automatic build_expect(input logic [23:0] ang, input logic [11:0] med);
        logic [6:0] x;
        exp_q = {};
        exp_q.push_back(ang[22:16]);
        exp_q.push_back(ang[14:8]);
        exp_q.push_back(ang[6:0]);
        exp_q.push_back(7'h2C);
        exp_q.push_back(digit_char(med[11:8]));
        exp_q.push_back(digit_char(med[7:4]));
        exp_q.push_back(digit_char(med[3:0]));
        exp_q.push_back(7'h23);
`ifdef SONAR_MSG_CHECKSUM_EN
        x = '0;
        foreach (exp_q[k]) x = x ^ exp_q[k];
        exp_q.push_back(x);
`else
        x = '0;
`endif
    endtask

    task automatic run_msg(input logic [23:0] ang, input logic [11:0] med, input int busy_at,
                           input bit change_in, input int reset_at, input string name);
        bit ok;
        int d;
        int pulses;
        build_expect(ang, med);
        angulo  = ang;
        medida  = med;
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        if (change_in) begin
            angulo = ~ang;
            medida = ~med;
        end
        chk($sformatf("%s_start_busy", name), 32'({ocupado, tx_partida, db_estado}), 32'({1'b1, 1'b0, 4'd1}));
        @(negedge clock);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s_partida%0d", name, i), 32'(tx_partida), 1);
            chk($sformatf("%s_char%0d", name, i), 32'(tx_dados), 32'(exp_q[i]));
            d  = $urandom_range(1, 6);
            ok = 1'b1;
            for (int w = 0; w < d; w++) begin
                iniciar = (w == 0 && i == busy_at);
                @(negedge clock);
                if (tx_partida !== 1'b0 || tx_dados !== exp_q[i] || db_estado !== 4'd3 ||
                    ocupado !== 1'b1 || pronto !== 1'b0) ok = 1'b0;
            end
            iniciar = 1'b0;
            chk($sformatf("%s_hold%0d", name, i), 32'(ok), 1);
            if (i == reset_at) begin
                reset = 1'b0;
                @(negedge clock);
                chk($sformatf("%s_rst_outputs", name),
                    32'({tx_partida, tx_dados, ocupado, pronto, db_estado}), 0);
                reset     = 1'b1;
                tx_pronto = 1'b1;
                @(negedge clock);
                tx_pronto = 1'b0;
                pulses = 0;
                ok     = 1'b1;
                repeat (20) begin
                    @(negedge clock);
                    if (tx_partida === 1'b1) pulses++;
                    if ({tx_dados, ocupado, pronto, db_estado} !== '0) ok = 1'b0;
                end
                chk($sformatf("%s_no_partida_after_rst", name), 32'(pulses), 0);
                chk($sformatf("%s_idle_after_rst", name), 32'(ok), 1);
                return;
            end
            tx_pronto = 1'b1;
            @(negedge clock);
            tx_pronto = 1'b0;
            @(negedge clock);
        end
        chk($sformatf("%s_fim", name), 32'({pronto, ocupado, tx_partida, db_estado}),
            32'({1'b1, 1'b1, 1'b0, 4'd5}));
        @(negedge clock);
        chk($sformatf("%s_idle", name), 32'({pronto, ocupado, db_estado}), 0);
        pulses = 0;
        repeat (20) begin
            @(negedge clock);
            if (tx_partida === 1'b1 || pronto === 1'b1 || ocupado === 1'b1) pulses++;
        end
        chk($sformatf("%s_quiet_after", name), 32'(pulses), 0);
    endtask

    initial begin
        logic [23:0] ra;
        logic [11:0] rm;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_outputs", 32'({tx_partida, tx_dados, ocupado, pronto, db_estado}), 0);
        reset = 1'b1;
        @(negedge clock);
        tx_pronto = 1'b1;
        @(negedge clock);
        tx_pronto = 1'b0;
        repeat (3) @(negedge clock);
        chk("idle_ignores_tx_pronto", 32'({tx_partida, ocupado, pronto, db_estado}), 0);

        run_msg(24'h303230, 12'h123, -1, 1'b0, -1, "basic");
`ifdef SONAR_MSG_CHECKSUM_EN
        chk("basic_checksum_value", 32'(exp_q[8]), 32'h0D);
`endif
        run_msg(24'h303230, 12'h1A9, -1, 1'b0, -1, "bad_bcd");
        run_msg(24'h313830, 12'h045, 2, 1'b0, -1, "busy_req");
        run_msg(24'h303230, 12'h123, -1, 1'b0, 3, "reset_mid");
        run_msg(24'h393039, 12'h987, -1, 1'b1, -1, "input_change");
        for (int r = 0; r < 6; r++) begin
            ra = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
            rm = 12'($urandom);
            run_msg(ra, rm, -1, r[0], -1, $sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
